// File: rtl/reg_pipeline_pkg.sv
// Shared defaults and sizing helpers for the reg_pipeline block.
// Both the top and its instantiating code use these to size the occupancy counter.
package reg_pipeline_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 3;

  // Bits needed to hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid flag plus payload, loaded when the slot is ready.
// clear drops the valid flag only; the payload is left as it was.
module pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      // NOTE: payload is reset too, so RESET_VAL is what out_data shows after reset.
      data  <= RESET_VAL;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/reg_pipeline.sv
// DEPTH-stage valid/ready register pipeline with bubble-collapsing backpressure,
// synchronous flush and a registered occupancy count.
module reg_pipeline
  import reg_pipeline_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [WIDTH-1:0]              out_data_n,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CW = count_width(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ready;
  logic [WIDTH-1:0] data [DEPTH];
  logic             in_fire;
  logic             out_fire;

  // A stage can take a word if it is empty or its own word moves on this cycle.
  always_comb begin : ready_chain
    logic downstream;
    // NOTE: every variable gets a value before the loop, so no latch is inferred.
    downstream = out_ready;
    ready      = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready[i]   = !valid[i] || downstream;
      downstream = ready[i];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             stage_in_valid;
    logic [WIDTH-1:0] stage_in_data;

    if (i == 0) begin : g_head
      assign stage_in_valid = in_valid;
      assign stage_in_data  = in_data;
    end else begin : g_body
      assign stage_in_valid = valid[i-1];
      assign stage_in_data  = data[i-1];
    end

    pipe_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .load    (ready[i]),
      .in_valid(stage_in_valid),
      .in_data (stage_in_data),
      .valid   (valid[i]),
      .data    (data[i])
    );
  end

  assign in_ready   = ready[0] && !flush && !reset;
  assign out_valid  = valid[DEPTH-1] && !flush;
  assign out_data   = data[DEPTH-1];
  assign out_data_n = ~out_data;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Words only enter or leave through the handshakes, so the population tracks them.
  always_ff @(posedge clk) begin
    if (reset || flush) count <= '0;
    else                count <= count + CW'(in_fire) - CW'(out_fire);
  end

endmodule

// File: doc/reg_pipeline.md
REG_PIPELINE -- requirements
Module: reg_pipeline

Interface
REQ-001: Parameter WIDTH, default 8, SHALL set the data width in bits (>=1).
REQ-002: Parameter DEPTH, default 3, SHALL set the number of register stages (>=1).
REQ-003: Parameter RESET_VAL, default 0 (WIDTH bits), SHALL set the reset value of every stage data register.
REQ-004: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005: reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006: flush  input  1  SHALL be a synchronous pipeline clear, active-high.
REQ-007: in_valid  input  1  SHALL mark in_data as valid.
REQ-008: in_ready  output  1  SHALL indicate the block accepts in_data this cycle.
REQ-009: in_data  input  WIDTH  SHALL be the input payload.
REQ-010: out_valid  output  1  SHALL mark out_data as valid.
REQ-011: out_ready  input  1  SHALL indicate the consumer accepts out_data this cycle.
REQ-012: out_data  output  WIDTH  SHALL be the data register of stage DEPTH-1.
REQ-013: out_data_n  output  WIDTH  SHALL be the bitwise complement of out_data.
REQ-014: count  output  $clog2(DEPTH+1)  SHALL be the number of valid stages.

Function
REQ-015: Stages SHALL be numbered 0 (input side) to DEPTH-1 (output side), each holding valid_i and data_i.
REQ-016: Stage readiness SHALL be ready_i = !valid_i || ready_(i+1), with ready_DEPTH = out_ready (bubble-collapsing backpressure).
REQ-017: in_ready SHALL equal ready_0 AND NOT flush; this path is combinational from out_ready by design.
REQ-018: When ready_i, valid_i SHALL load valid_(i-1) (stage 0: in_valid), and data_i SHALL load data_(i-1) (stage 0: in_data) only if that incoming valid is 1; otherwise data_i holds.
REQ-019: When !ready_i, stage i SHALL hold valid_i and data_i.
REQ-020: Input transfer SHALL occur iff in_valid && in_ready; output transfer iff out_valid && out_ready.
REQ-021: out_valid SHALL equal valid_(DEPTH-1) AND NOT flush.
REQ-022: Latency through an empty, unstalled pipeline SHALL be exactly DEPTH cycles; sustained throughput SHALL be one word per cycle.
REQ-023: Data order SHALL be preserved; no word SHALL be dropped or duplicated.
REQ-024: count SHALL be registered and equal the population of valid_0..valid_(DEPTH-1); simultaneous input and output transfer leaves count unchanged.
REQ-025: With all stages valid and out_ready=0, in_ready SHALL be 0 (full); out_ready rising SHALL raise in_ready in the same cycle.
REQ-026: flush=1 SHALL clear all valid bits at the next edge, block both handshakes that cycle, leave data registers unchanged, and set count to 0.
REQ-027: out_data_n SHALL be derived combinationally from out_data.

Reset
REQ-028: reset SHALL override flush and all handshakes.
REQ-029: After reset: every valid_i=0, every data_i=RESET_VAL, count=0, out_valid=0, out_data=RESET_VAL, out_data_n=~RESET_VAL.
REQ-030: in_ready SHALL be 0 while reset is asserted; reset mid-stream SHALL discard all held words.

Structure
REQ-031: Default WIDTH/DEPTH constants and the count-width function SHALL live in the shared package reg_pipeline_pkg.
REQ-032: One sub-module, pipe_stage (valid+data register with load enable, synchronous reset), SHALL be instantiated DEPTH times via generate.

Verification (WIDTH=8, DEPTH=3, RESET_VAL=0)
REQ-033: reset held 2 cycles with in_valid=1, in_data=0x5A -> out_valid=0, out_data=0x00, out_data_n=0xFF, count=0, in_ready=0.
REQ-034: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> 0x11 on out_data with out_valid=1 exactly 3 cycles after its accept, then 0x22, 0x33 on successive cycles.
REQ-035: out_ready=0, push 0xA1..0xA4 -> 0xA1..0xA3 accepted, in_ready=0 with 0xA4 pending, count=3; raise out_ready -> in_ready=1 same cycle, 0xA1 out, 0xA4 accepted.
REQ-036: out_ready=0, push 0x01, idle 1 cycle, push 0x02 -> bubble collapses, count=2, out_data=0x01, then 0x02 after 0x01 drains.
REQ-037: pipeline full, flush=1 with in_valid=1, out_ready=1 -> in_ready=0 and out_valid=0 that cycle, count=0 and out_valid=0 next cycle, no word transferred.
REQ-038: reset asserted with count=2 mid-stream -> next cycle count=0, out_valid=0, out_data=0x00; subsequent push 0x7E emerges 3 cycles after accept.
